axis_realign_p: RTL and testbench

- Parametrised successor to the 32-bit stream realigner.
- Compacts sparse AXI-Stream bytes (arbitrary tkeep) into a contiguous output stream, applies a per-packet start offset, and converts between input and output byte-lane endianness.
- Adds generic data width, a per-packet byte count on the last beat, and zero-byte packet dropping.
- Sits between DMA/host-side byte-enable sources and packed-stream consumers in the datapath.

---
 rtl/axis_realign_p.sv | 213 +++++++++++++++++++++
 tb/tb_axis_realign_p.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_realign_p.sv
// axis_realign_p: packs sparse AXI-Stream bytes into a contiguous output stream,
// inserts a per-packet start offset, converts lane endianness, reports the packet
// byte count on the last beat and drops zero-byte packets.
//
// Handshake: a transfer happens on a rising edge where valid && ready. A source
// holds data stable while valid && !ready. s_tready is registered-output style:
// it only needs the output register free, so no s_* input reaches m_* combinationally.
module axis_realign_p #(
    parameter int    DATA_BYTES        = 4,
    parameter string INPUT_BIG_ENDIAN  = "TRUE",
    parameter string OUTPUT_BIG_ENDIAN = "FALSE",
    parameter int    COUNT_WIDTH       = 16
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [8*DATA_BYTES-1:0]       s_tdata,
    input  logic [DATA_BYTES-1:0]         s_tkeep,
    input  logic                          s_tlast,
    input  logic [$clog2(DATA_BYTES)-1:0] s_tuser,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    output logic [8*DATA_BYTES-1:0]       m_tdata,
    output logic [DATA_BYTES-1:0]         m_tkeep,
    output logic                          m_tlast,
    output logic [COUNT_WIDTH-1:0]        m_tcount,
    output logic                          m_tvalid,
    input  logic                          m_tready
);
    localparam int N      = DATA_BYTES;
    localparam int PW     = $clog2(2 * DATA_BYTES);
    localparam bit IN_BE  = (INPUT_BIG_ENDIAN == "TRUE");
    localparam bit OUT_BE = (OUTPUT_BIG_ENDIAN == "TRUE");

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [7:0]               res_b_q [N];
    logic [7:0]               res_b_d [N];
    logic [N-1:0]             res_v_q, res_v_d;
    logic [PW-1:0]            res_cnt_q, res_cnt_d;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [8*N-1:0]           m_tdata_q, m_tdata_d;
    logic [N-1:0]             m_tkeep_q, m_tkeep_d;
    logic                     m_tlast_q, m_tlast_d;
    logic                     m_tvalid_q, m_tvalid_d;
    logic [COUNT_WIDTH-1:0]   m_tcount_q, m_tcount_d;

    // Merge buffer: residue (or offset slots) followed by the compacted kept bytes
    logic [7:0]               comb_b [2*N];
    logic [2*N-1:0]           comb_v;
    logic [PW-1:0]            base, total, kcnt;
    logic [8*N-1:0]           comb_pack_d, res_pack_d;
    logic [N-1:0]             comb_pack_k, res_pack_k;
    logic [COUNT_WIDTH:0]     cnt_sum;
    logic [COUNT_WIDTH-1:0]   cnt_next;
    logic                     accept, out_free;

    assign out_free = !m_tvalid_q || m_tready;
    assign s_tready = aresetn && (state_q != FLUSH) && out_free;
    assign accept   = s_tvalid && s_tready;

    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tlast  = m_tlast_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tcount = m_tcount_q;

    // Compact the incoming beat behind the residue and pre-pack candidate output beats
    always_comb begin
        int lane;
        comb_v = '0;
        for (int i = 0; i < 2*N; i++) comb_b[i] = 8'h00;
        base = (state_q == IDLE) ? PW'(s_tuser) : res_cnt_q;
        if (state_q != IDLE) begin
            for (int i = 0; i < N; i++) begin
                comb_b[i] = res_b_q[i];
                comb_v[i] = res_v_q[i];
            end
        end
        total = base;
        for (int j = 0; j < N; j++) begin
            lane = IN_BE ? (N - 1 - j) : j;
            if (s_tkeep[lane]) begin
                comb_b[total] = s_tdata[lane*8 +: 8];
                comb_v[total] = 1'b1;
                total         = total + 1'b1;
            end
        end
        kcnt = total - base;
        comb_pack_d = '0;
        comb_pack_k = '0;
        res_pack_d  = '0;
        res_pack_k  = '0;
        for (int p = 0; p < N; p++) begin
            lane = OUT_BE ? (N - 1 - p) : p;
            comb_pack_d[lane*8 +: 8] = comb_b[p];
            comb_pack_k[lane]        = comb_v[p];
            res_pack_d[lane*8 +: 8]  = res_b_q[p];
            res_pack_k[lane]         = res_v_q[p];
        end
        cnt_sum  = {1'b0, cnt_q} + (COUNT_WIDTH+1)'(kcnt);
        cnt_next = cnt_sum[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : cnt_sum[COUNT_WIDTH-1:0];
    end

    // Next-state, residue, byte counter and output register loading
    always_comb begin
        state_d    = state_q;
        res_b_d    = res_b_q;
        res_v_d    = res_v_q;
        res_cnt_d  = res_cnt_q;
        cnt_d      = cnt_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        m_tcount_d = m_tcount_q;
        if (out_free) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            m_tkeep_d  = '0;
            m_tcount_d = '0;
        end
        case (state_q)
            IDLE, RUN: begin
                if (accept) begin
                    cnt_d = cnt_next;
                    if (total >= PW'(N)) begin
                        m_tdata_d  = comb_pack_d;
                        m_tkeep_d  = comb_pack_k;
                        m_tvalid_d = 1'b1;
                        for (int i = 0; i < N; i++) begin
                            res_b_d[i] = comb_b[i+N];
                            res_v_d[i] = comb_v[i+N];
                        end
                        res_cnt_d = total - PW'(N);
                        if (!s_tlast) begin
                            state_d = RUN;
                        end else if (res_cnt_d == '0) begin
                            m_tlast_d  = 1'b1;
                            m_tcount_d = cnt_next;
                            cnt_d      = '0;
                            state_d    = IDLE;
                        end else begin
                            state_d = FLUSH;
                        end
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            res_b_d[i] = comb_b[i];
                            res_v_d[i] = comb_v[i];
                        end
                        res_cnt_d = total;
                        state_d   = RUN;
                        if (s_tlast) begin
                            // A packet with no data bytes produces nothing, offset or not
                            if (cnt_next != '0) begin
                                m_tdata_d  = comb_pack_d;
                                m_tkeep_d  = comb_pack_k;
                                m_tvalid_d = 1'b1;
                                m_tlast_d  = 1'b1;
                                m_tcount_d = cnt_next;
                            end
                            res_v_d   = '0;
                            res_cnt_d = '0;
                            cnt_d     = '0;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    m_tdata_d  = res_pack_d;
                    m_tkeep_d  = res_pack_k;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = 1'b1;
                    m_tcount_d = cnt_q;
                    res_v_d    = '0;
                    res_cnt_d  = '0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, residue, counter and output registers with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            for (int i = 0; i < N; i++) res_b_q[i] <= 8'h00;
            res_v_q    <= '0;
            res_cnt_q  <= '0;
            cnt_q      <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tcount_q <= '0;
        end else begin
            state_q    <= state_d;
            for (int i = 0; i < N; i++) res_b_q[i] <= res_b_d[i];
            res_v_q    <= res_v_d;
            res_cnt_q  <= res_cnt_d;
            cnt_q      <= cnt_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            m_tlast_q  <= m_tlast_d;
            m_tvalid_q <= m_tvalid_d;
            m_tcount_q <= m_tcount_d;
        end
    end
endmodule

// File: tb/tb_axis_realign_p.sv
// Directed testbench for axis_realign_p (4 bytes, big-endian in, little-endian out).
module tb_axis_realign_p;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic [1:0]  s_tuser;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic [15:0] m_tcount;
    logic        m_tvalid;
    logic        m_tready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] dq[$];
    logic [3:0]  kq[$];
    logic        lq[$];
    logic [15:0] cq[$];

    // clock / reset
    always #5 aclk = ~aclk;

    axis_realign_p #(
        .DATA_BYTES(4), .INPUT_BIG_ENDIAN("TRUE"),
        .OUTPUT_BIG_ENDIAN("FALSE"), .COUNT_WIDTH(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tcount(m_tcount),
        .m_tvalid(m_tvalid), .m_tready(m_tready)
    );

    // record every output handshake; sampled on the falling edge
    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) begin
            dq.push_back(m_tdata);
            kq.push_back(m_tkeep);
            lq.push_back(m_tlast);
            cq.push_back(m_tcount);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask(input logic [3:0] k);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    // driver: present one beat and hold it until accepted
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] u);
        bit done;
        done     = 1'b0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge aclk);
            if (s_tready) done = 1'b1;
            @(posedge aclk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout observed=no_accept expected=accept");
        end
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic [15:0] c);
        chk({tag, "_avail"}, 64'(dq.size() != 0), 64'd1);
        if (dq.size() != 0) begin
            chk({tag, "_keep"},  64'(kq[0]), 64'(k));
            chk({tag, "_data"},  64'(dq[0] & mask(k)), 64'(d & mask(k)));
            chk({tag, "_last"},  64'(lq[0]), 64'(l));
            chk({tag, "_count"}, 64'(cq[0]), 64'(c));
            void'(dq.pop_front());
            void'(kq.pop_front());
            void'(lq.pop_front());
            void'(cq.pop_front());
        end
    endtask

    task automatic expect_none(input string tag);
        chk(tag, 64'(dq.size()), 64'd0);
        dq.delete();
        kq.delete();
        lq.delete();
        cq.delete();
    endtask

    initial begin
        aresetn  = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;

        // reset state
        @(negedge aclk);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        idle(2);
        @(negedge aclk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast",  64'(m_tlast),  64'd0);
        chk("rst_m_tkeep",  64'(m_tkeep),  64'd0);
        chk("rst_m_tdata",  64'(m_tdata),  64'd0);
        chk("rst_m_tcount", 64'(m_tcount), 64'd0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_s_tready", 64'(s_tready), 64'd1);
        @(posedge aclk);
        #1;

        // 1: aligned full beat
        send(32'h00112233, 4'b1111, 1'b1, 2'd0);
        idle(3);
        expect_beat("t1", 32'h33221100, 4'b1111, 1'b1, 16'd4);
        expect_none("t1_extra");

        // 2: offset 1 overflows into a flush beat
        send(32'h00112233, 4'b1111, 1'b1, 2'd1);
        @(negedge aclk);
        chk("t2_flush_ready", 64'(s_tready), 64'd0);
        idle(3);
        expect_beat("t2a", 32'h22110000, 4'b1110, 1'b0, 16'd0);
        expect_beat("t2b", 32'h00000033, 4'b0001, 1'b1, 16'd4);
        expect_none("t2_extra");

        // 3: sparse single-byte beats
        send(32'h00000000, 4'b1000, 1'b0, 2'd0);
        send(32'h00110000, 4'b0100, 1'b0, 2'd0);
        send(32'h00002200, 4'b0010, 1'b0, 2'd0);
        idle(3);
        expect_none("t3_early");
        send(32'h00000033, 4'b0001, 1'b1, 2'd0);
        idle(3);
        expect_beat("t3", 32'h33221100, 4'b1111, 1'b1, 16'd4);
        expect_none("t3_extra");

        // 4: short packet, zero-byte packet with offset, then a normal packet
        send(32'h00112233, 4'b1100, 1'b1, 2'd0);
        send(32'h12345678, 4'b0000, 1'b1, 2'd2);
        send(32'hAABBCCDD, 4'b1111, 1'b1, 2'd0);
        idle(3);
        expect_beat("t4a", 32'h00001100, 4'b0011, 1'b1, 16'd2);
        expect_beat("t4c", 32'hDDCCBBAA, 4'b1111, 1'b1, 16'd4);
        expect_none("t4_extra");

        // 5: backpressure during a 3-beat packet
        m_tready = 1'b0;
        send(32'h01020304, 4'b1111, 1'b0, 2'd0);
        s_tdata  = 32'h05060708;
        s_tkeep  = 4'b1111;
        s_tlast  = 1'b0;
        s_tuser  = 2'd0;
        s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("t5_hold_valid", 64'(m_tvalid), 64'd1);
            chk("t5_hold_data",  64'(m_tdata),  64'h04030201);
            chk("t5_hold_ready", 64'(s_tready), 64'd0);
        end
        @(posedge aclk);
        #1 m_tready = 1'b1;
        send(32'h05060708, 4'b1111, 1'b0, 2'd0);
        send(32'h090A0B0C, 4'b1111, 1'b1, 2'd0);
        idle(3);
        expect_beat("t5a", 32'h04030201, 4'b1111, 1'b0, 16'd0);
        expect_beat("t5b", 32'h08070605, 4'b1111, 1'b0, 16'd0);
        expect_beat("t5c", 32'h0C0B0A09, 4'b1111, 1'b1, 16'd12);
        expect_none("t5_extra");

        // 6: reset in the middle of a packet
        send(32'h11223344, 4'b1111, 1'b0, 2'd1);
        send(32'h55667788, 4'b1111, 1'b0, 2'd0);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("t6_rst_ready", 64'(s_tready), 64'd0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("t6_rst_valid", 64'(m_tvalid), 64'd0);
        chk("t6_rst_keep",  64'(m_tkeep),  64'd0);
        @(posedge aclk);
        #1;
        send(32'h44556677, 4'b1111, 1'b1, 2'd0);
        idle(3);
        expect_beat("t6a", 32'h33221100, 4'b1110, 1'b0, 16'd0);
        expect_beat("t6b", 32'h77665544, 4'b1111, 1'b1, 16'd4);
        expect_none("t6_extra");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
